// File: rtl/mul_seq_ctrl_if.sv
// Handshake and writeback bundle between the execute stage and the
// multi-cycle multiply sequencer.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);
  logic             valid_in;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [RADDR-1:0] rd_in;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             wb_valid;
  logic [RADDR-1:0] wb_rd;
  logic [WIDTH-1:0] wb_data;

  modport master (
    output valid_in, start, op_a, op_b, rd_in, flush,
    input  stall, busy, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  valid_in, start, op_a, op_b, rd_in, flush,
    output stall, busy, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle shift-add multiply sequencer for the R-type mul instruction.
// Accepts a decoded start strobe, stalls the front of the pipeline for the
// fixed iteration count, then presents a one-cycle register-file writeback
// of the low WIDTH product bits.
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_seq_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]         state_r;
  logic [1:0]         next_state_s;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_sum_s;
  logic [CW-1:0]      cnt_r;
  logic [RADDR-1:0]   rd_q_r;
  logic               accept_s;
  logic               last_iter_s;
  logic               stall_s;
  logic               busy_r;
  logic               wb_valid_r;
  logic [RADDR-1:0]   wb_rd_r;
  logic [WIDTH-1:0]   wb_data_r;

  assign accept_s    = bus.valid_in & bus.start & ~bus.flush;
  assign last_iter_s = (cnt_r == CNT_LAST);
  // Carry out of the 2*WIDTH accumulator is intentionally dropped.
  assign acc_sum_s   = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

  // Next-state selection; flush in RUN beats the final iteration.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_RUN;
        else          next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (bus.flush)        next_state_s = ST_IDLE;
        else if (last_iter_s) next_state_s = ST_DONE;
        else                  next_state_s = ST_RUN;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Pipeline hold: raised in the accept cycle and through RUN, dropped by flush
  // and forced low while reset is asserted.
  always_comb begin
    stall_s = 1'b0;
    if (!rst_n) begin
      stall_s = 1'b0;
    end else if (state_r == ST_RUN) begin
      stall_s = ~bus.flush;
    end else if (state_r == ST_IDLE) begin
      stall_s = accept_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  // State, datapath iteration and registered writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      mcand_r    <= '0;
      mplier_r   <= '0;
      acc_r      <= '0;
      cnt_r      <= '0;
      rd_q_r     <= '0;
      busy_r     <= 1'b0;
      wb_valid_r <= 1'b0;
      wb_rd_r    <= '0;
      wb_data_r  <= '0;
    end else begin
      state_r    <= next_state_s;
      busy_r     <= (next_state_s != ST_IDLE);
      wb_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            mcand_r  <= {{WIDTH{1'b0}}, bus.op_a};
            mplier_r <= bus.op_b;
            acc_r    <= '0;
            cnt_r    <= '0;
            rd_q_r   <= bus.rd_in;
          end
        end
        ST_RUN: begin
          if (!bus.flush) begin
            acc_r    <= acc_sum_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_ONE;
            if (last_iter_s) begin
              wb_data_r  <= acc_sum_s[WIDTH-1:0];
              wb_rd_r    <= rd_q_r;
              wb_valid_r <= (rd_q_r != '0);
            end
          end
        end
        ST_DONE: begin
          // start still belongs to the held instruction; nothing to load.
          wb_valid_r <= 1'b0;
        end
        default: begin
          wb_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall    = stall_s;
  assign bus.busy     = busy_r;
  assign bus.wb_valid = wb_valid_r;
  assign bus.wb_rd    = wb_rd_r;
  assign bus.wb_data  = wb_data_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a writeback scoreboard.
module tb_mul_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int RADDR = 5;

  typedef struct packed {
    logic [RADDR-1:0] rd;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  mul_seq_ctrl_if #(.WIDTH(WIDTH), .RADDR(RADDR)) bus ();

  mul_seq_ctrl #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc, stall_hi, stall_last, busy_hi, busy_first, busy_last, wb_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, track stall/busy, score writebacks.
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (bus.stall === 1'b1) begin stall_hi++; stall_last = cyc; end
    if (bus.busy === 1'b1) begin
      busy_hi++;
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    if (bus.wb_valid !== 1'b0) begin
      wb_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("spurious_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_data", {32'd0, bus.wb_data}, {32'd0, e.data});
        chk("wb_rd", {59'd0, bus.wb_rd}, {59'd0, e.rd});
      end
    end
  endtask

  // Present a mul at the current falling edge (this cycle is T0).
  task automatic start_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [RADDR-1:0] rd, input bit push);
    logic [63:0] p;
    exp_t e;
    bus.valid_in = 1'b1;
    bus.start    = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.rd_in    = rd;
    cyc = 0; stall_hi = 0; stall_last = -1;
    busy_hi = 0; busy_first = -1; busy_last = -1; wb_cyc = -1;
    #1;
    chk("stall_T0", {63'd0, bus.stall}, 64'd1);
    if (bus.stall === 1'b1) begin stall_hi = 1; stall_last = 0; end
    p = {32'd0, a} * {32'd0, b};
    if (push && rd != 5'd0) begin
      e.rd   = rd;
      e.data = p[31:0];
      exp_q.push_back(e);
    end
  endtask

  // Full single multiply with latency and strobe-width checks.
  task automatic do_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [RADDR-1:0] rd, input string tag);
    start_mul(a, b, rd, 1'b1);
    step();
    bus.valid_in = 1'b0;
    bus.start    = 1'b0;
    repeat (34) step();
    chk({tag, "_stall_cycles"}, stall_hi, 33);
    chk({tag, "_stall_last"}, stall_last, 32);
    chk({tag, "_busy_span"}, {busy_first[31:0], busy_last[31:0]}, {32'd1, 32'd33});
    chk({tag, "_wb_cycle"}, wb_cyc, (rd != 5'd0) ? 33 : -1);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.start    = 1'b0;
    bus.op_a     = 32'd0;
    bus.op_b     = 32'd0;
    bus.rd_in    = 5'd0;
    bus.flush    = 1'b0;
    cyc = 0; stall_hi = 0; stall_last = -1;
    busy_hi = 0; busy_first = -1; busy_last = -1; wb_cyc = -1;

    repeat (2) @(negedge clk);
    chk("rst_outputs", {bus.stall, bus.busy, bus.wb_valid, bus.wb_rd, bus.wb_data},
        {3'b000, 5'd0, 32'd0});
    rst_n = 1'b1;
    step();

    // Basic multiply and hold of last writeback values.
    do_mul(32'd7, 32'd6, 5'd5, "basic");
    chk("hold_wb_data", {32'd0, bus.wb_data}, 64'd42);
    chk("hold_wb_valid", {63'd0, bus.wb_valid}, 64'd0);

    // Overflow wrap of the low product bits.
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, "wrap_ones");
    do_mul(32'h0001_0000, 32'h0001_0000, 5'd10, "wrap_zero");
    do_mul(32'hDEAD_BEEF, 32'h1234_5678, 5'd31, "mixed");

    // Zero destination: full stall, no writeback.
    do_mul(32'd3, 32'd4, 5'd0, "rd_zero");

    // Flush at T10: stall drops that cycle, IDLE next, restart at T12.
    start_mul(32'd100, 32'd100, 5'd7, 1'b0);
    step();
    bus.valid_in = 1'b0;
    bus.start    = 1'b0;
    repeat (9) step();
    bus.flush = 1'b1;
    #1;
    chk("flush10_stall", {63'd0, bus.stall}, 64'd0);
    step();
    bus.flush = 1'b0;
    chk("flush10_busy_T11", {63'd0, bus.busy}, 64'd0);
    step();
    do_mul(32'd11, 32'd13, 5'd4, "after_flush");

    // Flush on the final iteration beats DONE.
    start_mul(32'd9, 32'd9, 5'd2, 1'b0);
    step();
    bus.valid_in = 1'b0;
    bus.start    = 1'b0;
    repeat (31) step();
    chk("flush32_stall_pre", {63'd0, bus.stall}, 64'd1);
    bus.flush = 1'b1;
    #1;
    chk("flush32_stall", {63'd0, bus.stall}, 64'd0);
    step();
    bus.flush = 1'b0;
    chk("flush32_busy", {63'd0, bus.busy}, 64'd0);
    repeat (3) step();
    chk("flush32_no_wb", wb_cyc, -1);

    // Reset mid-run at T15.
    start_mul(32'd100, 32'd100, 5'd6, 1'b0);
    step();
    bus.valid_in = 1'b0;
    bus.start    = 1'b0;
    repeat (14) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {bus.stall, bus.busy, bus.wb_valid, bus.wb_rd, bus.wb_data},
        {3'b000, 5'd0, 32'd0});
    bus.valid_in = 1'b1;
    bus.start    = 1'b1;
    #1;
    chk("midrst_stall_gated", {63'd0, bus.stall}, 64'd0);
    bus.valid_in = 1'b0;
    bus.start    = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    do_mul(32'd2, 32'd3, 5'd8, "after_reset");

    // Back-to-back with start held through DONE.
    start_mul(32'd12, 32'd12, 5'd1, 1'b1);
    repeat (33) step();
    chk("b2b_first_wb_cycle", wb_cyc, 33);
    chk("b2b_done_stall", {63'd0, bus.stall}, 64'd0);
    chk("b2b_done_busy", {63'd0, bus.busy}, 64'd1);
    step();
    bus.op_a  = 32'd5;
    bus.op_b  = 32'd5;
    bus.rd_in = 5'd3;
    begin
      exp_t e;
      e.rd   = 5'd3;
      e.data = 32'd25;
      exp_q.push_back(e);
    end
    #1;
    chk("b2b_T34_stall", {63'd0, bus.stall}, 64'd1);
    chk("b2b_T34_busy", {63'd0, bus.busy}, 64'd0);
    step();
    bus.valid_in = 1'b0;
    bus.start    = 1'b0;
    repeat (35) step();
    chk("b2b_second_wb_cycle", wb_cyc, 67);
    chk("b2b_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle multiply sequencer for the R-type `mul` instruction (opcode 12, funct 50).
- Accepts the decoded `mul_Start` strobe and its register operands, then runs an iterative shift-add multiply.
- Holds the pipeline with `stall` while the multiply runs.
- Presents a one-cycle writeback of the low WIDTH product bits to the register file.
- Sits beside the ALU in execute; its result feeds the writeback mux selected when `mux2_ALU = 0`.

## Interface
Parameters:
- WIDTH, 32, operand and result width
- RADDR, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  execute-stage instruction valid
- start  in  1  mul_Start from the control decoder
- op_a  in  WIDTH  rs operand value
- op_b  in  WIDTH  rt operand value
- rd_in  in  RADDR  destination register
- flush  in  1  synchronous kill of the in-flight multiply
- stall  out  1  hold the fetch/decode/execute stages
- busy  out  1  high in RUN or DONE
- wb_valid  out  1  one-cycle register-file write strobe
- wb_rd  out  RADDR  write address
- wb_data  out  WIDTH  product[WIDTH-1:0]

## Operation
- **States:** IDLE, RUN, DONE. Encoding is free.
- **Internal registers:**
  - mcand: 2*WIDTH bits
  - mplier: WIDTH bits
  - acc: 2*WIDTH bits
  - cnt: $clog2(WIDTH)+1 bits
  - rd_q: RADDR bits
- **IDLE:**
  - Acceptance condition: `valid_in & start & ~flush`.
  - On acceptance, load: mcand = zero-extended op_a, mplier = op_b, acc = 0, cnt = 0, rd_q = rd_in.
  - Transition: go to RUN.
  - Otherwise remain in IDLE.
- **RUN (one iteration per cycle):**
  - If mplier[0], then acc += mcand. The sum is 2*WIDTH bits; carry out of the top is dropped.
  - mcand <<= 1; mplier >>= 1; cnt += 1.
  - On the iteration where cnt == WIDTH-1: go to DONE, and register wb_data = the final acc[WIDTH-1:0], wb_rd = rd_q, wb_valid = (rd_q != 0).
  - There is no early termination; latency is fixed.
- **DONE:**
  - Lasts exactly one cycle; wb_valid is high in this cycle only (if rd_q != 0).
  - `start` is ignored here, because it still belongs to the held mul instruction.
  - Next state is IDLE. Back-to-back muls are accepted from IDLE one cycle later.
- **Flush:**
  - In RUN: go to IDLE, no writeback, `stall` low in that same cycle.
  - In DONE: the writeback still completes, since the instruction has already retired.
  - In IDLE: flush blocks acceptance.
- **rd == 0:** the full sequence and stall still run; wb_valid stays 0.
- **Operand signedness:** unsigned. Low WIDTH bits are identical for two's-complement operands.

## Timing
- **stall** is combinational: `(state==RUN) | (state==IDLE & valid_in & start & ~flush)`, gated low by `~flush` in RUN.
- **Cycle numbering:** accept cycle T0.
  - RUN occupies T1..T(WIDTH).
  - DONE is T(WIDTH+1).
  - stall is high T0..T(WIDTH): 33 cycles for WIDTH=32.
  - wb_valid is high at T(WIDTH+1), and stall is low in that cycle.
- **Output timing:** wb_valid, wb_rd and wb_data are registered. wb_data and wb_rd hold their last value after DONE; only wb_valid returns to 0.
- **busy** is registered state decode, high T1..T(WIDTH+1).
- **Reset (rst_n low, asynchronous):**
  - state = IDLE; all internal registers 0.
  - wb_valid = 0, wb_rd = 0, wb_data = 0, busy = 0.
  - stall = 0 while rst_n is low, regardless of inputs.
  - Reset mid-RUN discards the operation with no writeback.
- **Simultaneous events:** when flush and the final RUN iteration coincide, flush wins: no DONE and no wb_valid.

## Test plan
- **Basic multiply:** op_a=7, op_b=6, rd_in=5, start pulse in IDLE -> stall high exactly 33 cycles; wb_valid one cycle at T33 with wb_data=42, wb_rd=5; busy high T1..T33.
- **Overflow wrap:** op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, rd_in=9 -> wb_data=0x00000001. Also op_a=0x00010000, op_b=0x00010000 -> wb_data=0x00000000.
- **Zero destination:** rd_in=0, op_a=3, op_b=4 -> stall still 33 cycles; wb_valid never asserts.
- **Flush mid-run:** flush at T10 -> stall low at T10; state IDLE at T11; no wb_valid; a new start at T12 is accepted normally. Also flush at T32 (last iteration) -> no wb_valid.
- **Reset mid-run:** rst_n low at T15 -> all outputs 0 immediately; after release, a start with op_a=2, op_b=3 yields wb_data=6 with full latency.
- **Back-to-back:** start held high through DONE -> no re-accept in DONE; second mul (op_a=5, op_b=5, rd_in=3) presented at T34 accepted; wb_data=25 at T67.
